// File: rtl/mem_responder.sv
// mem_responder: dual-port (fetch + load/store) memory model with halt mailbox and sticky bus error
module mem_responder #(
  parameter int          ADDR_BITS  = 14,
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] HALT_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  output logic [31:0] instruction,
  input  logic [31:0] read_address,
  input  logic        read,
  output logic [31:0] DATA_in,
  input  logic [31:0] write_address,
  input  logic [31:0] DATA_out,
  input  logic [3:0]  write,
  output logic        halted,
  output logic [31:0] halt_code,
  output logic        bus_err
);
  localparam int L = RD_LATENCY;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] mem [2**ADDR_BITS];
  logic [31:0] i_w, r_w, w_w, mask, old_w, fetch_d, load_d;
  logic [ADDR_BITS-1:0] i_idx, r_idx, w_idx;
  logic i_ok, r_ok, w_ok, r_halt, w_halt, st_en, err_set;
  logic [31:0] i_pipe [L];
  logic [31:0] d_pipe [L];
  logic [L-1:0] v_pipe;
  // address decode, same-word store merge for loads, and error detection
  always_comb begin
    i_w = (i_address - BASE) >> 2;
    r_w = (read_address - BASE) >> 2;
    w_w = (write_address - BASE) >> 2;
    i_ok = (i_w >> ADDR_BITS) == 32'd0;
    r_ok = (r_w >> ADDR_BITS) == 32'd0;
    w_ok = (w_w >> ADDR_BITS) == 32'd0;
    i_idx = i_w[ADDR_BITS-1:0];
    r_idx = r_w[ADDR_BITS-1:0];
    w_idx = w_w[ADDR_BITS-1:0];
    r_halt = read_address == HALT_ADDR;
    w_halt = write_address == HALT_ADDR;
    st_en = write != 4'd0;
    mask = {{8{write[3]}}, {8{write[2]}}, {8{write[1]}}, {8{write[0]}}};
    old_w = mem[r_idx];
    fetch_d = i_ok ? mem[i_idx] : NOP;
    load_d = r_ok ? ((st_en && w_ok && w_idx == r_idx) ? (DATA_out & mask) | (old_w & ~mask) : old_w)
           : r_halt ? halt_code : 32'd0;
    err_set = !i_ok || (read && !r_ok && !r_halt) || (st_en && !w_ok && !w_halt);
  end
  // array store on strobed lanes; a store while reset is low is dropped, contents survive reset
  always_ff @(posedge clk or negedge reset) begin
    if (reset && st_en && w_ok)
      for (int n = 0; n < 4; n++)
        if (write[n]) mem[w_idx][8*n +: 8] <= DATA_out[8*n +: 8];
  end
  // read pipelines (data stages hold when no load is in flight), halt mailbox and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < L; k++) begin
        i_pipe[k] <= 32'd0;
        d_pipe[k] <= 32'd0;
      end
      v_pipe <= '0;
      halted <= 1'b0;
      halt_code <= 32'd0;
      bus_err <= 1'b0;
    end else begin
      i_pipe[0] <= fetch_d;
      if (read) d_pipe[0] <= load_d;
      v_pipe <= (v_pipe << 1) | L'(read);
      for (int k = 1; k < L; k++) begin
        i_pipe[k] <= i_pipe[k-1];
        if (v_pipe[k-1]) d_pipe[k] <= d_pipe[k-1];
      end
      if (err_set) bus_err <= 1'b1;
      if (st_en && w_halt) begin
        halted <= 1'b1;
        if (!halted) halt_code <= DATA_out & mask;
      end
    end
  end
  assign instruction = i_pipe[L-1];
  assign DATA_in = d_pipe[L-1];
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synchronous memory model serving both bus masters of the core: the instruction fetch port and the data load/store port.
- Sits outside TOP, on the far side of the core's memory interface.
- Port names mirror the core's names, so TOP connects with implicit port binding.
- Also provides a halt mailbox and a sticky bus-error flag for simulation and benches.

Parameters:
- ADDR_BITS, 14: word-address width; the array holds 2**ADDR_BITS 32-bit words.
- BASE, 32'h0000_0000: byte address of word 0; must be aligned to 4*2**ADDR_BITS.
- RD_LATENCY, 1: cycles from sampled address to valid read data on both ports; legal range 1..4.
- HALT_ADDR, 32'h8000_0000: byte address of the halt mailbox; must lie outside the array range.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_address  in  32  instruction fetch byte address; sampled every cycle.
- instruction  out  32  fetched word, RD_LATENCY cycles after i_address is sampled.
- read_address  in  32  load byte address; sampled when read=1.
- read  in  1  load request, one per cycle when high.
- DATA_in  out  32  load data, RD_LATENCY cycles after a request.
- write_address  in  32  store byte address.
- DATA_out  in  32  store data, byte lanes aligned to the word.
- write  in  4  store byte strobes; bit n writes lane [8n+7:8n]; 4'b0000 means no store.
- halted  out  1  sticky; set by any store to HALT_ADDR.
- halt_code  out  32  word captured by the first store to HALT_ADDR.
- bus_err  out  1  sticky; set by any out-of-range access.

Behaviour:
- Reset (reset=0, asynchronous):
  - instruction, DATA_in, halt_code := 0; halted, bus_err := 0.
  - All latency-pipeline stages cleared.
  - The memory array is not reset; contents are preserved across reset.
- Address decode:
  - word index = (addr - BASE)[ADDR_BITS+1:2]; addr[1:0] is ignored.
  - In range: BASE <= addr < BASE + 4*2**ADDR_BITS.
- Instruction port:
  - Reads every cycle; unconditional pipeline of depth RD_LATENCY.
  - An out-of-range fetch returns 32'h0000_0013 (NOP) and sets bus_err.
- Load port:
  - With read=1, the word appears on DATA_in exactly RD_LATENCY edges later.
  - With read=0 nothing is launched, and DATA_in holds its last delivered value indefinitely.
  - Back-to-back reads are fully pipelined, one result per cycle, in order.
  - An out-of-range load returns 0 and sets bus_err. A load of HALT_ADDR returns halt_code and does not set bus_err.
- Store port:
  - Store occurs when write != 0.
  - In range: strobed lanes are updated at the edge; unstrobed lanes are unchanged.
  - To HALT_ADDR: halted := 1. If halted was 0, halt_code := DATA_out with unstrobed lanes forced to 0. Later halt stores leave halt_code unchanged.
  - Any other address: no array update, and bus_err := 1.
- Simultaneous events in the same cycle:
  - Load and store to the same word: the load returns the merged word (new data on strobed lanes, old data on the rest).
  - Fetch and store to the same word: the fetch returns the old word, with no forwarding. The core flushes via branch after self-modifying code.
  - Different words: independent.
- Reset asserted mid-operation:
  - In-flight pipeline results are discarded; no output is produced for them.
  - A store on the same edge as reset assertion is dropped.
- halted does not gate the ports; the memory keeps responding. The bench decides when to stop.
- Latency:
  - RD_LATENCY=1 means a registered array read.
  - Each additional stage is a plain register delay on both data and valid.

Test Plan:
- Reset value check:
  - Assert reset for 3 cycles -> instruction=0, DATA_in=0, halted=0, bus_err=0, halt_code=0.
  - Preload word 5 = 32'hDEADBEEF, pulse reset, then read 0x14 -> 32'hDEADBEEF (array not cleared).
- Byte strobes:
  - Word 2 = 32'h11223344; store write=4'b0101, DATA_out=32'hAABBCCDD to 0x08.
  - Read 0x08 -> 32'h11BB33DD.
  - Read 0x0A (misaligned) -> same word.
- Latency:
  - RD_LATENCY=3; read=1 at 0x00,0x04,0x08 on cycles 0,1,2 -> DATA_in valid on cycles 3,4,5 in order.
  - read=0 afterwards -> DATA_in holds the last value.
- Same-cycle hazard:
  - Word 4 = 0; same cycle: store 32'hCAFEF00D with write=4'b1100 to 0x10, load 0x10, fetch 0x10.
  - DATA_in = 32'hCAFE0000; instruction = 0.
- Halt mailbox:
  - Store 32'h0000_0001 (write=4'b1111) to HALT_ADDR -> halted=1, halt_code=1.
  - Second store of 32'h0000_0002 -> halt_code stays 1.
  - Load HALT_ADDR -> 1; bus_err stays 0.
- Out of range:
  - ADDR_BITS=10; fetch 0x0000_1000 -> instruction=32'h0000_0013, bus_err=1.
  - Load 0x2000 -> DATA_in=0.
  - A later store to 0x2000 leaves the array unchanged; bus_err stays 1 until reset.
